// File: rtl/store_unit_if.sv
// Request/memory bus of the store unit: control-side request plus data-memory port.
interface store_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    // Master is the control FSM and memory side; slave is the store unit itself.
    modport master (
        output start, funct3, addr, wdata, mem_rdata,
        input  mem_addr, mem_wdata, mem_wr, busy, done, err
    );

    modport slave (
        input  start, funct3, addr, wdata, mem_rdata,
        output mem_addr, mem_wdata, mem_wr, busy, done, err
    );
endinterface

// File: rtl/store_unit.sv
// Store unit: byte-lane read-modify-write of one 64-bit data-memory doubleword.
// Optional macro MISALIGN_TRAP_EN: misaligned stores trap instead of being force-aligned.
module store_unit #(
    parameter int READ_LATENCY = 1
) (
    input logic         clk,
    input logic         rst,
    store_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] merged_q, merged_d;

    logic        accept;
    logic        rdLast;
    logic [1:0]  reqSize;
    logic        reqFault;
    logic [2:0]  laneOff;
    logic [7:0]  baseMask;
    logic [7:0]  byteMask;
    logic [63:0] bitMask;
    logic [63:0] shiftedData;
    logic [63:0] mergedData;
    logic        memWr;
    logic        doneOut;
    logic        errOut;
    logic        busyOut;
    logic        unusedAddrHi;

    assign unusedAddrHi = ^bus.addr[63:32];
    assign reqSize      = bus.funct3[1:0];
    assign accept       = (state_q == IDLE) && bus.start;
    assign rdLast       = (cnt_q == 3'(READ_LATENCY - 1));

`ifdef MISALIGN_TRAP_EN
    logic reqMisaligned;

    // A request is misaligned when any offset bit below its size is set.
    always_comb begin
        unique case (reqSize)
            2'd0:    reqMisaligned = 1'b0;
            2'd1:    reqMisaligned = bus.addr[0];
            2'd2:    reqMisaligned = |bus.addr[1:0];
            default: reqMisaligned = |bus.addr[2:0];
        endcase
    end

    assign reqFault = bus.funct3[2] | reqMisaligned;
`else
    assign reqFault = bus.funct3[2];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Doubleword stores skip the read phase since every lane is overwritten.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (reqFault) begin
                        state_d = ERR;
                    end else if (reqSize == 2'd3) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (rdLast) begin
                    state_d = WR;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        memWr   = 1'b0;
        doneOut = 1'b0;
        errOut  = 1'b0;
        busyOut = (state_q != IDLE);
        unique case (state_q)
            WR:   memWr = 1'b1;
            DONE: doneOut = 1'b1;
            ERR: begin
                errOut  = 1'b1;
                doneOut = 1'b1;
            end
            default: ;
        endcase
    end

    // Offsets are aligned down to the access size; in the trap build they already are.
    always_comb begin
        unique case (size_q)
            2'd0: begin
                laneOff  = addr_q[2:0];
                baseMask = 8'h01;
            end
            2'd1: begin
                laneOff  = {addr_q[2:1], 1'b0};
                baseMask = 8'h03;
            end
            2'd2: begin
                laneOff  = {addr_q[2], 2'b00};
                baseMask = 8'h0F;
            end
            default: begin
                laneOff  = 3'b000;
                baseMask = 8'hFF;
            end
        endcase
    end

    assign byteMask    = baseMask << laneOff;
    assign shiftedData = wdata_q << {laneOff, 3'b000};

    always_comb begin
        bitMask = '0;
        for (int b = 0; b < 8; b++) begin
            bitMask[8*b +: 8] = {8{byteMask[b]}};
        end
    end

    assign mergedData = (bus.mem_rdata & ~bitMask) | (shiftedData & bitMask);

    // The request is latched on acceptance; the merge result lands on the final read cycle.
    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        cnt_d    = cnt_q;
        merged_d = merged_q;
        if (accept) begin
            addr_d  = bus.addr[31:0];
            wdata_d = bus.wdata;
            size_d  = reqSize;
            cnt_d   = '0;
            if ((reqSize == 2'd3) && !reqFault) begin
                merged_d = bus.wdata;
            end
        end else if (state_q == RD) begin
            cnt_d = cnt_q + 3'd1;
            if (rdLast) begin
                merged_d = mergedData;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            cnt_q    <= '0;
            merged_q <= '0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            cnt_q    <= cnt_d;
            merged_q <= merged_d;
        end
    end

    assign bus.mem_addr  = {addr_q[31:3], 3'b000};
    assign bus.mem_wdata = merged_q;
    assign bus.mem_wr    = memWr;
    assign bus.busy      = busyOut;
    assign bus.done      = doneOut;
    assign bus.err       = errOut;

endmodule
